// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the RV32I fetch stage: FSM encodings, NOP, reset PC and widths.
// Optional build macro used by the fetch stage: IF_PERF_CNT_EN (perf counters).
package instr_fetch_unit_pkg;

    typedef enum logic [1:0] {
        IF_FETCH = 2'd0,
        IF_HOLD  = 2'd1,
        IF_DRAIN = 2'd2
    } if_state_e;

    localparam logic [31:0] RV_NOP           = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int          INSTR_W          = 32;

endpackage

// File: rtl/instr_fetch_unit_out_reg.sv
// fetch_out_reg: single-entry valid/ready slot holding {pc, instr} for decode, with flush.
// Handshake: a slot transfers on a rising edge where valid & consume; load refills it the same edge.
module fetch_out_reg
    import instr_fetch_unit_pkg::*;
#(
    parameter int DATA_W = INSTR_W
) (
    input  logic              iCLK,
    input  logic              iRST_n,
    input  logic              flush,
    input  logic              load,
    input  logic [31:0]       load_pc,
    input  logic [DATA_W-1:0] load_instr,
    input  logic              consume,
    output logic [31:0]       pc,
    output logic [DATA_W-1:0] instr,
    output logic              valid
);

    // Flush wins over a same-edge load so a wrong-path instruction never lands in the slot.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            pc    <= 32'h0;
            instr <= DATA_W'(RV_NOP);
            valid <= 1'b0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            pc    <= load_pc;
            instr <= load_instr;
            valid <= 1'b1;
        end else if (consume) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// RV32I fetch stage: owns the PC, talks to instructions_cache, feeds decode through a one-entry slot.
// Build option IF_PERF_CNT_EN adds oSTALL_CNT / oFETCH_CNT performance counters.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int          ADDR_W   = 8,
    parameter int          DATA_W   = INSTR_W,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              iCLK,
    input  logic              iRST_n,
    output logic [ADDR_W-1:0] oIC_ADDR,
    input  logic [DATA_W-1:0] iIC_INSTR,
    input  logic              iIC_READY,
    output logic [31:0]       oIF_PC,
    output logic [DATA_W-1:0] oIF_INSTR,
    output logic              oIF_VALID,
    input  logic              iID_READY,
    input  logic              iREDIRECT,
    input  logic [31:0]       iREDIRECT_PC,
`ifdef IF_PERF_CNT_EN
    output logic [31:0]       oSTALL_CNT,
    output logic [31:0]       oFETCH_CNT,
`endif
    output if_state_e         dbg_state
);

    if_state_e   state;
    logic [31:0] pc;
    logic        slot_free;
    logic        capture;

    assign slot_free = !oIF_VALID || iID_READY;
    assign capture   = (state == IF_FETCH) && iIC_READY && slot_free && !iREDIRECT;

    // DRAIN spends one cycle after any address jump so a refill for the old address is never captured.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state <= IF_DRAIN;
            pc    <= RESET_PC & ~32'h3;
        end else if (iREDIRECT) begin
            state <= IF_DRAIN;
            pc    <= iREDIRECT_PC & ~32'h3;
        end else begin
            unique case (state)
                IF_FETCH: begin
                    if (iIC_READY) begin
                        if (slot_free) pc <= pc + 32'd4;
                        else           state <= IF_HOLD;
                    end
                end
                IF_HOLD: begin
                    if (iID_READY) state <= IF_FETCH;
                end
                IF_DRAIN: state <= IF_FETCH;
                default:  state <= IF_DRAIN;
            endcase
        end
    end

    assign oIC_ADDR  = pc[ADDR_W+1:2];
    assign dbg_state = state;

    fetch_out_reg #(
        .DATA_W(DATA_W)
    ) u_out_reg (
        .iCLK      (iCLK),
        .iRST_n    (iRST_n),
        .flush     (iREDIRECT),
        .load      (capture),
        .load_pc   (pc),
        .load_instr(iIC_INSTR),
        .consume   (iID_READY),
        .pc        (oIF_PC),
        .instr     (oIF_INSTR),
        .valid     (oIF_VALID)
    );

`ifdef IF_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] fetch_cnt;

    // Counters survive redirects; only reset clears them.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            stall_cnt <= 32'h0;
            fetch_cnt <= 32'h0;
        end else begin
            if (state == IF_FETCH && !iIC_READY) stall_cnt <= stall_cnt + 32'd1;
            if (capture)                         fetch_cnt <= fetch_cnt + 32'd1;
        end
    end

    assign oSTALL_CNT = stall_cnt;
    assign oFETCH_CNT = fetch_cnt;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus randomized traffic against a
// transaction-level model of the expected instruction stream. Honours IF_PERF_CNT_EN if defined.
module tb_instr_fetch_unit;
    import instr_fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    // Main DUT (RESET_PC = 0)
    logic [7:0]  ic_addr;
    logic [31:0] ic_instr;
    logic        ic_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_valid;
    logic        id_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    if_state_e   dbg_state;
    logic [31:0] stall_cnt;
    logic [31:0] fetch_cnt;

    // Wrap DUT (RESET_PC = 0x3FC)
    logic [7:0]  w_addr;
    logic [31:0] w_ic_instr;
    logic        w_ic_ready;
    logic [31:0] w_pc;
    logic [31:0] w_instr;
    logic        w_valid;
    logic        w_id_ready;
    logic        w_redirect;
    logic [31:0] w_redirect_pc;
    if_state_e   w_dbg_state;
    logic [31:0] w_stall_cnt;
    logic [31:0] w_fetch_cnt;

    // Cache model: word ROM; the cycle after a redirect it returns a stale (garbage) refill.
    logic [31:0] rom [256];
    logic        stale;
    assign ic_instr   = stale ? 32'hDEAD_BEEF : rom[ic_addr];
    assign w_ic_instr = rom[w_addr];

    instr_fetch_unit #(.ADDR_W(8), .DATA_W(32), .RESET_PC(32'h0)) dut (
        .iCLK(clk), .iRST_n(rst_n), .oIC_ADDR(ic_addr), .iIC_INSTR(ic_instr),
        .iIC_READY(ic_ready), .oIF_PC(if_pc), .oIF_INSTR(if_instr), .oIF_VALID(if_valid),
        .iID_READY(id_ready), .iREDIRECT(redirect), .iREDIRECT_PC(redirect_pc),
`ifdef IF_PERF_CNT_EN
        .oSTALL_CNT(stall_cnt), .oFETCH_CNT(fetch_cnt),
`endif
        .dbg_state(dbg_state)
    );

    instr_fetch_unit #(.ADDR_W(8), .DATA_W(32), .RESET_PC(32'h0000_03FC)) dut_wrap (
        .iCLK(clk), .iRST_n(rst_n), .oIC_ADDR(w_addr), .iIC_INSTR(w_ic_instr),
        .iIC_READY(w_ic_ready), .oIF_PC(w_pc), .oIF_INSTR(w_instr), .oIF_VALID(w_valid),
        .iID_READY(w_id_ready), .iREDIRECT(w_redirect), .iREDIRECT_PC(w_redirect_pc),
`ifdef IF_PERF_CNT_EN
        .oSTALL_CNT(w_stall_cnt), .oFETCH_CNT(w_fetch_cnt),
`endif
        .dbg_state(w_dbg_state)
    );

`ifndef IF_PERF_CNT_EN
    assign stall_cnt   = 32'h0;
    assign fetch_cnt   = 32'h0;
    assign w_stall_cnt = 32'h0;
    assign w_fetch_cnt = 32'h0;
`endif

    // Scoreboard: in-order stream of {pc, instr} that decode must see next.
    logic [63:0] exp_q[$];
    logic [31:0] next_pc;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_deliv = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic fill_q();
        while (exp_q.size() < 2) begin
            exp_q.push_back({next_pc, rom[next_pc[9:2]]});
            next_pc = next_pc + 32'd4;
        end
    endtask

    // Slot must hold the head of the stream; cache address is the first instruction not yet in the slot.
    task automatic check_model();
        logic [63:0] head;
        logic [63:0] nxt;
        logic [31:0] fetch_pc;
        fill_q();
        head = exp_q[0];
        nxt  = exp_q[1];
        if (if_valid) begin
            check("slot_pc", {32'h0, if_pc}, {32'h0, head[63:32]});
            check("slot_instr", {32'h0, if_instr}, {32'h0, head[31:0]});
            fetch_pc = nxt[63:32];
        end else begin
            fetch_pc = head[63:32];
        end
        check("ic_addr", {56'h0, ic_addr}, {56'h0, fetch_pc[9:2]});
    endtask

    // Driver: apply one cycle of inputs at the falling edge, advance, then check at the next falling edge.
    task automatic step(input logic icr, input logic idr, input logic rd, input logic [31:0] rpc);
        ic_ready    = icr;
        id_ready    = idr;
        redirect    = rd;
        redirect_pc = rpc;
        if (rd) begin
            exp_q.delete();
            next_pc = rpc & ~32'h3;
        end else if (if_valid && idr) begin
            void'(exp_q.pop_front());
            n_deliv++;
        end
        @(negedge clk);
        stale = rd;
        check_model();
    endtask

    logic [31:0] stall0;
    logic [31:0] fetch0;

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = $urandom & 32'h7FFF_FFFF;
        rom[0] = 32'h0000_0023; rom[1] = 32'h0000_0646; rom[2] = 32'h0000_0452;
        rom[3] = 32'h0000_1183; rom[4] = 32'h0000_0523; rom[5] = 32'h0000_0a13;
        rom[6] = 32'h0000_0c63; rom[7] = 32'h0000_0e33;

        // Clock/reset
        rst_n = 1'b0; ic_ready = 1'b0; id_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        stale = 1'b0; w_ic_ready = 1'b0; w_id_ready = 1'b0; w_redirect = 1'b0; w_redirect_pc = 32'h0;
        next_pc = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_valid", {63'h0, if_valid}, 64'h0);
        check("rst_ic_addr", {56'h0, ic_addr}, 64'h0);
        check("rst_instr", {32'h0, if_instr}, 64'h13);
        check("rst_pc", {32'h0, if_pc}, 64'h0);
        check("rst_state", {62'h0, dbg_state}, {62'h0, IF_DRAIN});
        check("rst_wrap_addr", {56'h0, w_addr}, 64'hFF);
`ifdef IF_PERF_CNT_EN
        check("rst_stall_cnt", {32'h0, stall_cnt}, 64'h0);
        check("rst_fetch_cnt", {32'h0, fetch_cnt}, 64'h0);
`endif
        rst_n = 1'b1;

        // First edge is DRAIN: ready cache data is not captured
        step(1'b1, 1'b1, 1'b0, 32'h0);
        check("drain_no_capture", {63'h0, if_valid}, 64'h0);
        check("drain_to_fetch", {62'h0, dbg_state}, {62'h0, IF_FETCH});

        // Streaming hits: one instruction per cycle
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0);
            check("stream_valid", {63'h0, if_valid}, 64'h1);
            check("stream_pc", {32'h0, if_pc}, 64'(4 * i));
        end

        // Miss at word address 2
        step(1'b1, 1'b1, 1'b1, 32'h0000_0008);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        check("miss_pre_valid", {63'h0, if_valid}, 64'h0);
        stall0 = stall_cnt;
        fetch0 = fetch_cnt;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 32'h0);
            check("miss_addr_hold", {56'h0, ic_addr}, 64'h2);
            check("miss_no_valid", {63'h0, if_valid}, 64'h0);
        end
        step(1'b1, 1'b1, 1'b0, 32'h0);
        check("miss_deliver_valid", {63'h0, if_valid}, 64'h1);
        check("miss_deliver_instr", {32'h0, if_instr}, 64'h0452);
`ifdef IF_PERF_CNT_EN
        check("miss_stall_delta", {32'h0, stall_cnt - stall0}, 64'h3);
        check("miss_fetch_delta", {32'h0, fetch_cnt - fetch0}, 64'h1);
`endif

        // Backpressure: slot full, decode stalled, cache ready
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check("bp_pc_stable", {32'h0, if_pc}, 64'h8);
        check("bp_addr_stable", {56'h0, ic_addr}, 64'h3);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check("bp_pc_stable2", {32'h0, if_pc}, 64'h8);
        check("bp_state_hold", {62'h0, dbg_state}, {62'h0, IF_HOLD});
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        check("bp_resume_pc", {32'h0, if_pc}, 64'hC);

        // Redirect during a miss
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b1, 32'h0000_0013);
        check("redir_addr", {56'h0, ic_addr}, 64'h4);
        check("redir_valid", {63'h0, if_valid}, 64'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        check("redir_drain_ignore", {63'h0, if_valid}, 64'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        check("redir_pc", {32'h0, if_pc}, 64'h10);
        check("redir_instr", {32'h0, if_instr}, 64'h0523);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 19) == 0, $urandom);
        end
        check("progress", {63'h0, n_deliv > 300}, 64'h1);

        // Address wrap on the second instance
        check("wrap_pre_addr", {56'h0, w_addr}, 64'hFF);
        w_ic_ready = 1'b1;
        w_id_ready = 1'b1;
        @(negedge clk);
        check("wrap_pc0", {32'h0, w_pc}, 64'h3FC);
        check("wrap_instr0", {32'h0, w_instr}, {32'h0, rom[255]});
        check("wrap_addr0", {56'h0, w_addr}, 64'h00);
        @(negedge clk);
        check("wrap_pc1", {32'h0, w_pc}, 64'h400);
        check("wrap_instr1", {32'h0, w_instr}, {32'h0, rom[0]});
        check("wrap_addr1", {56'h0, w_addr}, 64'h01);
        check("wrap_valid", {63'h0, w_valid}, 64'h1);
        check("wrap_state", {62'h0, w_dbg_state}, {62'h0, IF_FETCH});
`ifdef IF_PERF_CNT_EN
        check("wrap_fetch_cnt", {32'h0, w_fetch_cnt}, 64'h2);
        check("wrap_stall_nonzero", {63'h0, w_stall_cnt != 32'h0}, 64'h1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
